// File: rtl/pc_trace_monitor.sv
// PC trace monitor: samples the fetch PC, keeps the newest DEPTH PCs in a ring
// buffer, flags stalls and expected-PC mismatches, and keeps saturating counters.
module pc_trace_monitor #(
  parameter int  PC_W        = 19,
  parameter int  DEPTH       = 8,
  parameter int  CNT_W       = 16,
  parameter int  STALL_LIMIT = 4,
  parameter int  CHANGE_ONLY = 0,
  localparam int IW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             exp_valid,
  input  logic [PC_W-1:0]  exp_pc,
  input  logic [IW-1:0]    rd_idx,
  output logic [PC_W-1:0]  rd_data,
  output logic             rd_hit,
  output logic [IW:0]      fill,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] capture_count,
  output logic             stall,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] first_bad_cycle,
  output logic [PC_W-1:0]  first_bad_pc
);
  localparam int               REP_W     = $clog2(STALL_LIMIT + 1);
  localparam logic [IW:0]      FILL_MAX  = (IW+1)'(DEPTH);
  localparam logic [REP_W-1:0] REP_MAX   = REP_W'(STALL_LIMIT);
  localparam logic [REP_W-1:0] REP_STALL = REP_W'(STALL_LIMIT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [PC_W-1:0]  mem_q [DEPTH];
  logic [IW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [IW:0]      fill_q, fill_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, cap_q, cap_d, mmc_q, mmc_d, fbc_q, fbc_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d, fbp_q, fbp_d, rd_data_q, rd_data_d;
  logic             have_last_q, have_last_d, stall_q, stall_d, mm_q, mm_d;
  logic             rd_hit_q, rd_hit_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             same_pc, capture, fail;
  logic [IW-1:0]    rd_addr;

  assign same_pc = have_last_q && (pc_in == last_pc_q);
  assign capture = en && ((CHANGE_ONLY == 0) || !same_pc);
  assign fail    = en && exp_valid && (pc_in != exp_pc);
  // Age 0 is the slot just behind the write pointer.
  assign rd_addr = wr_ptr_q - IW'(1) - rd_idx;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    cyc_d       = cyc_q;
    cap_d       = cap_q;
    mmc_d       = mmc_q;
    fbc_d       = fbc_q;
    fbp_d       = fbp_q;
    last_pc_d   = last_pc_q;
    have_last_d = have_last_q;
    stall_d     = stall_q;
    mm_d        = mm_q;
    rep_d       = rep_q;
    rd_data_d   = mem_q[rd_addr];
    rd_hit_d    = ({1'b0, rd_idx} < fill_q);

    if (capture) begin
      wr_ptr_d = wr_ptr_q + IW'(1);
      if (fill_q != FILL_MAX) fill_d = fill_q + (IW+1)'(1);
      cap_d = sat_inc(cap_q);
    end

    if (en) begin
      cyc_d       = sat_inc(cyc_q);
      last_pc_d   = pc_in;
      have_last_d = 1'b1;
      if (!same_pc)            rep_d = '0;
      else if (rep_q != REP_MAX) rep_d = rep_q + REP_W'(1);
      stall_d = (rep_d >= REP_STALL);
    end

    if (fail) begin
      mm_d  = 1'b1;
      mmc_d = sat_inc(mmc_q);
      if (!mm_q) begin
        fbc_d = cyc_q;
        fbp_d = pc_in;
      end
    end

    if (clear) begin
      wr_ptr_d    = '0;
      fill_d      = '0;
      cyc_d       = '0;
      cap_d       = '0;
      mmc_d       = '0;
      fbc_d       = '0;
      fbp_d       = '0;
      last_pc_d   = '0;
      have_last_d = 1'b0;
      stall_d     = 1'b0;
      mm_d        = 1'b0;
      rep_d       = '0;
      rd_data_d   = '0;
      rd_hit_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      cyc_q       <= '0;
      cap_q       <= '0;
      mmc_q       <= '0;
      fbc_q       <= '0;
      fbp_q       <= '0;
      last_pc_q   <= '0;
      have_last_q <= 1'b0;
      stall_q     <= 1'b0;
      mm_q        <= 1'b0;
      rep_q       <= '0;
      rd_data_q   <= '0;
      rd_hit_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      cyc_q       <= cyc_d;
      cap_q       <= cap_d;
      mmc_q       <= mmc_d;
      fbc_q       <= fbc_d;
      fbp_q       <= fbp_d;
      last_pc_q   <= last_pc_d;
      have_last_q <= have_last_d;
      stall_q     <= stall_d;
      mm_q        <= mm_d;
      rep_q       <= rep_d;
      rd_data_q   <= rd_data_d;
      rd_hit_q    <= rd_hit_d;
    end
  end

  // Buffer storage carries no reset; fill gates which entries are meaningful.
  always_ff @(posedge clk) begin
    if (capture && !clear) mem_q[wr_ptr_q] <= pc_in;
  end

  assign rd_data         = rd_data_q;
  assign rd_hit          = rd_hit_q;
  assign fill            = fill_q;
  assign cycle_count     = cyc_q;
  assign capture_count   = cap_q;
  assign stall           = stall_q;
  assign mismatch        = mm_q;
  assign mismatch_count  = mmc_q;
  assign first_bad_cycle = fbc_q;
  assign first_bad_pc    = fbp_q;
endmodule

// File: tb/tb_pc_trace_monitor.sv
// Bench for pc_trace_monitor: three instances (every-sample, change-only, 4-bit counters)
// share one stimulus stream and are compared against a queue-based reference model.
module tb_pc_trace_monitor;
  localparam int PC_W = 19;
  localparam int DEPTH = 8;
  localparam int IW = 3;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic en = 1'b0;
  logic exp_valid = 1'b0;
  logic [PC_W-1:0] pc_in = '0;
  logic [PC_W-1:0] exp_pc = '0;
  logic [IW-1:0] rd_idx = '0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0] rd_data;
    logic            rd_hit;
    logic [IW:0]     fill;
    logic [15:0]     cyc;
    logic [15:0]     cap;
    logic [15:0]     mmc;
    logic [15:0]     fbc;
    logic [PC_W-1:0] fbp;
    logic            stall;
    logic            mm;
  } outs_t;

  logic [PC_W-1:0] rd_data0, rd_data1, rd_data2, fbp0, fbp1, fbp2;
  logic            rd_hit0, rd_hit1, rd_hit2, stall0, stall1, stall2, mm0, mm1, mm2;
  logic [IW:0]     fill0, fill1, fill2;
  logic [15:0]     cyc0, cap0, mmc0, fbc0, cyc1, cap1, mmc1, fbc1;
  logic [3:0]      cyc2, cap2, mmc2, fbc2;
  outs_t act0, act1, act2;

  assign act0 = {rd_data0, rd_hit0, fill0, cyc0, cap0, mmc0, fbc0, fbp0, stall0, mm0};
  assign act1 = {rd_data1, rd_hit1, fill1, cyc1, cap1, mmc1, fbc1, fbp1, stall1, mm1};
  assign act2 = {rd_data2, rd_hit2, fill2, 12'd0, cyc2, 12'd0, cap2, 12'd0, mmc2,
                 12'd0, fbc2, fbp2, stall2, mm2};

  pc_trace_monitor #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(16), .STALL_LIMIT(SL), .CHANGE_ONLY(0)) u_dut (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .pc_in(pc_in), .exp_valid(exp_valid),
    .exp_pc(exp_pc), .rd_idx(rd_idx), .rd_data(rd_data0), .rd_hit(rd_hit0), .fill(fill0),
    .cycle_count(cyc0), .capture_count(cap0), .stall(stall0), .mismatch(mm0),
    .mismatch_count(mmc0), .first_bad_cycle(fbc0), .first_bad_pc(fbp0));

  pc_trace_monitor #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(16), .STALL_LIMIT(SL), .CHANGE_ONLY(1)) u_dut_co (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .pc_in(pc_in), .exp_valid(exp_valid),
    .exp_pc(exp_pc), .rd_idx(rd_idx), .rd_data(rd_data1), .rd_hit(rd_hit1), .fill(fill1),
    .cycle_count(cyc1), .capture_count(cap1), .stall(stall1), .mismatch(mm1),
    .mismatch_count(mmc1), .first_bad_cycle(fbc1), .first_bad_pc(fbp1));

  pc_trace_monitor #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(4), .STALL_LIMIT(SL), .CHANGE_ONLY(0)) u_dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .pc_in(pc_in), .exp_valid(exp_valid),
    .exp_pc(exp_pc), .rd_idx(rd_idx), .rd_data(rd_data2), .rd_hit(rd_hit2), .fill(fill2),
    .cycle_count(cyc2), .capture_count(cap2), .stall(stall2), .mismatch(mm2),
    .mismatch_count(mmc2), .first_bad_cycle(fbc2), .first_bad_pc(fbp2));

  int nchk = 0;
  int npass = 0;

  // Reference model state, one slot per instance.
  int unsigned hist [3][$];
  int unsigned m_cyc[3], m_cap[3], m_mmc[3], m_fbc[3], m_fbp[3], m_last[3], m_run[3];
  bit          m_have[3], m_mm[3];
  int unsigned e_rd_data[3];
  bit          e_rd_hit[3], e_rd_chk[3];

  function automatic outs_t pick(input int m);
    case (m)
      0:       return act0;
      1:       return act1;
      default: return act2;
    endcase
  endfunction

  function automatic int unsigned sat(input int m, input int unsigned v);
    int unsigned mx;
    mx = (m == 2) ? 15 : 65535;
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic chk(input string nm, input int unsigned a, input int unsigned e);
    nchk++;
    if (a == e) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, a, e);
  endtask

  task automatic model_reset(input int m);
    hist[m].delete();
    m_cyc[m] = 0; m_cap[m] = 0; m_mmc[m] = 0; m_fbc[m] = 0; m_fbp[m] = 0;
    m_last[m] = 0; m_run[m] = 0; m_have[m] = 0; m_mm[m] = 0;
    e_rd_data[m] = 0; e_rd_hit[m] = 0; e_rd_chk[m] = 1;
  endtask

  task automatic model_step(input int m);
    int unsigned n, pc, ri;
    bit same;
    if (clear) begin
      model_reset(m);
      return;
    end
    n  = hist[m].size();
    ri = 32'(rd_idx);
    e_rd_hit[m] = (ri < n);
    e_rd_chk[m] = e_rd_hit[m];
    if (e_rd_hit[m]) e_rd_data[m] = hist[m][n - 1 - ri];
    if (en) begin
      pc   = 32'(pc_in);
      same = m_have[m] && (pc == m_last[m]);
      if (exp_valid && (pc_in != exp_pc)) begin
        if (!m_mm[m]) begin
          m_fbc[m] = m_cyc[m];
          m_fbp[m] = pc;
        end
        m_mm[m]  = 1;
        m_mmc[m] = sat(m, m_mmc[m]);
      end
      if (m != 1 || !same) begin
        hist[m].push_back(pc);
        if (hist[m].size() > DEPTH) void'(hist[m].pop_front());
        m_cap[m] = sat(m, m_cap[m]);
      end
      m_run[m]  = same ? ((m_run[m] < 1000) ? m_run[m] + 1 : m_run[m]) : 1;
      m_cyc[m]  = sat(m, m_cyc[m]);
      m_last[m] = pc;
      m_have[m] = 1;
    end
  endtask

  task automatic check_inst(input int m);
    outs_t a;
    string p;
    a = pick(m);
    p = $sformatf("u%0d", m);
    chk({p, ".fill"}, 32'(a.fill), int'(hist[m].size()));
    chk({p, ".cycle_count"}, 32'(a.cyc), m_cyc[m]);
    chk({p, ".capture_count"}, 32'(a.cap), m_cap[m]);
    chk({p, ".mismatch"}, 32'(a.mm), 32'(m_mm[m]));
    chk({p, ".mismatch_count"}, 32'(a.mmc), m_mmc[m]);
    chk({p, ".first_bad_cycle"}, 32'(a.fbc), m_fbc[m]);
    chk({p, ".first_bad_pc"}, 32'(a.fbp), m_fbp[m]);
    chk({p, ".stall"}, 32'(a.stall), (m_run[m] >= SL) ? 1 : 0);
    chk({p, ".rd_hit"}, 32'(a.rd_hit), 32'(e_rd_hit[m]));
    if (e_rd_chk[m]) chk({p, ".rd_data"}, 32'(a.rd_data), e_rd_data[m]);
  endtask

  task automatic cycle(input bit e, input int unsigned pc, input bit ev,
                       input int unsigned ep, input int unsigned rd, input bit clr);
    en = e; pc_in = PC_W'(pc); exp_valid = ev; exp_pc = PC_W'(ep);
    rd_idx = IW'(rd); clear = clr;
    @(posedge clk);
    for (int m = 0; m < 3; m++) model_step(m);
    #1;
    for (int m = 0; m < 3; m++) check_inst(m);
  endtask

  typedef struct {
    bit en; int unsigned pc; bit ev; int unsigned ep; int unsigned rd;
    int unsigned fill, cyc, cap, mmc, fbc, fbp; bit stall, mm, hit, chk_rd; int unsigned rdd;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit e, input int unsigned pc, input bit ev, input int unsigned ep,
                     input int unsigned rd, input int unsigned fl, input int unsigned cy,
                     input int unsigned ca, input int unsigned mc, input int unsigned fc,
                     input int unsigned fp, input bit st, input bit mm, input bit hit,
                     input int unsigned rdd);
    vec_t v;
    v.en = e; v.pc = pc; v.ev = ev; v.ep = ep; v.rd = rd; v.fill = fl; v.cyc = cy; v.cap = ca;
    v.mmc = mc; v.fbc = fc; v.fbp = fp; v.stall = st; v.mm = mm; v.hit = hit; v.chk_rd = hit;
    v.rdd = rdd;
    tbl.push_back(v);
  endtask

  initial begin
    int unsigned prev_pc, pc, ep;
    bit e, ev, clr;
    outs_t a;

    // PCs 0..9, mismatches at samples 7 (exp 8) and 9 (exp 0)
    add(1, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 2, 2, 2, 0, 0, 0, 0, 0, 1, 0);
    add(1, 2, 1, 2, 0, 3, 3, 3, 0, 0, 0, 0, 0, 1, 1);
    add(1, 3, 1, 3, 0, 4, 4, 4, 0, 0, 0, 0, 0, 1, 2);
    add(1, 4, 1, 4, 0, 5, 5, 5, 0, 0, 0, 0, 0, 1, 3);
    add(1, 5, 1, 5, 0, 6, 6, 6, 0, 0, 0, 0, 0, 1, 4);
    add(1, 6, 1, 6, 0, 7, 7, 7, 0, 0, 0, 0, 0, 1, 5);
    add(1, 7, 1, 8, 0, 8, 8, 8, 1, 7, 7, 0, 1, 1, 6);
    add(1, 8, 1, 8, 0, 8, 9, 9, 1, 7, 7, 0, 1, 1, 7);
    add(1, 9, 1, 0, 0, 8, 10, 10, 2, 7, 7, 0, 1, 1, 8);
    // Oldest entry readback, then en low with a wrong expected PC
    add(0, 100, 0, 0, 7, 8, 10, 10, 2, 7, 7, 0, 1, 1, 2);
    for (int k = 0; k < 5; k++) add(0, 200 + k, 1, 5, 0, 8, 10, 10, 2, 7, 7, 0, 1, 1, 9);
    // PC held at 5 for six samples, then 6
    add(1, 5, 0, 0, 0, 8, 11, 11, 2, 7, 7, 0, 1, 1, 9);
    add(1, 5, 0, 0, 0, 8, 12, 12, 2, 7, 7, 0, 1, 1, 5);
    add(1, 5, 0, 0, 0, 8, 13, 13, 2, 7, 7, 0, 1, 1, 5);
    add(1, 5, 0, 0, 0, 8, 14, 14, 2, 7, 7, 1, 1, 1, 5);
    add(1, 5, 0, 0, 0, 8, 15, 15, 2, 7, 7, 1, 1, 1, 5);
    add(1, 5, 0, 0, 0, 8, 16, 16, 2, 7, 7, 1, 1, 1, 5);
    add(1, 6, 0, 0, 0, 8, 17, 17, 2, 7, 7, 0, 1, 1, 5);

    for (int m = 0; m < 3; m++) model_reset(m);
    #12;
    for (int m = 0; m < 3; m++) check_inst(m);
    @(negedge clk);
    reset = 1'b1;
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].en, tbl[i].pc, tbl[i].ev, tbl[i].ep, tbl[i].rd, 1'b0);
      a = act0;
      chk($sformatf("tbl%0d.fill", i), 32'(a.fill), tbl[i].fill);
      chk($sformatf("tbl%0d.cycle_count", i), 32'(a.cyc), tbl[i].cyc);
      chk($sformatf("tbl%0d.capture_count", i), 32'(a.cap), tbl[i].cap);
      chk($sformatf("tbl%0d.mismatch_count", i), 32'(a.mmc), tbl[i].mmc);
      chk($sformatf("tbl%0d.first_bad_cycle", i), 32'(a.fbc), tbl[i].fbc);
      chk($sformatf("tbl%0d.first_bad_pc", i), 32'(a.fbp), tbl[i].fbp);
      chk($sformatf("tbl%0d.stall", i), 32'(a.stall), 32'(tbl[i].stall));
      chk($sformatf("tbl%0d.mismatch", i), 32'(a.mm), 32'(tbl[i].mm));
      chk($sformatf("tbl%0d.rd_hit", i), 32'(a.rd_hit), 32'(tbl[i].hit));
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d.rd_data", i), 32'(a.rd_data), tbl[i].rdd);
    end

    // Change-only capture: 3,3,3,4,4,5
    cycle(1, 77, 0, 0, 0, 1);
    chk("co_clear.fill", 32'(act1.fill), 0);
    foreach (tbl[i]) if (i < 6) cycle(1, (i < 3) ? 3 : (i < 5) ? 4 : 5, 0, 0, 0, 0);
    chk("co.capture_count", 32'(act1.cap), 3);
    chk("co.cycle_count", 32'(act1.cyc), 6);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 0, k, 0);
      chk($sformatf("co.rd_hit%0d", k), 32'(act1.rd_hit), (k < 3) ? 1 : 0);
      if (k < 3) chk($sformatf("co.rd_data%0d", k), 32'(act1.rd_data), 5 - k);
    end

    // Clear alongside a sample, then an asynchronous reset pulse between edges
    cycle(1, 42, 1, 1, 0, 1);
    chk("clr.cycle_count", 32'(act0.cyc), 0);
    chk("clr.mismatch", 32'(act0.mm), 0);
    cycle(1, 43, 0, 0, 0, 0);
    chk("post_clr.cycle_count", 32'(act0.cyc), 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) model_reset(m);
    for (int m = 0; m < 3; m++) check_inst(m);
    chk("async.cycle_count", 32'(act0.cyc), 0);
    #1 reset = 1'b1;
    cycle(1, 44, 0, 0, 0, 0);
    chk("post_rst.cycle_count", 32'(act0.cyc), 1);
    chk("post_rst.capture_count", 32'(act0.cap), 1);

    // Randomized traffic against the reference model
    prev_pc = 0;
    for (int n = 0; n < 600; n++) begin
      e  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 0) pc = prev_pc;
      else if ($urandom_range(0, 7) == 0) pc = $urandom_range(0, (1 << PC_W) - 1);
      else pc = $urandom_range(0, 3);
      ev  = ($urandom_range(0, 1) == 1);
      ep  = ($urandom_range(0, 3) == 0) ? (pc ^ 1) : pc;
      clr = ($urandom_range(0, 99) == 0);
      cycle(e, pc, ev, ep, $urandom_range(0, DEPTH - 1), clr);
      prev_pc = pc;
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
